// File: rtl/pll_drp_ctrl.sv
// PLL DRP command controller: address/write/read sequencing on the DRP bus plus a PLL
// reset-and-lock-wait "apply" command. Define PLL_DRP_VERIFY_EN to read back every write.
module pll_drp_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000
) (
    input  logic       mdclk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo,
    output logic       pll_rst,
    input  logic       pll_lock,
    output logic       locked
);

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, WR, RD, RDCAP, RST, LOCKWAIT, DONE
`ifdef PLL_DRP_VERIFY_EN
        , VRD, VCAP
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         cmd_q;
    logic [7:0]         addr_q, wdata_q, rdata_q;
    logic               err_q, timeout;
    logic [CNT_W-1:0]   cnt;
    logic               lock_p0, lock_p1, lock_q;
    logic [1:0]         hi_cnt;

    always_ff @(posedge mdclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    case (req_cmd)
                        2'b00, 2'b01: state_nxt = ADDR;
                        2'b10:        state_nxt = RST;
                        default:      state_nxt = DONE;
                    endcase
                end
            end
            ADDR:  state_nxt = (cmd_q == 2'b00) ? WR : RD;
`ifdef PLL_DRP_VERIFY_EN
            WR:    state_nxt = VRD;
            VRD:   state_nxt = VCAP;
            VCAP:  state_nxt = DONE;
`else
            WR:    state_nxt = DONE;
`endif
            RD:    state_nxt = RDCAP;
            RDCAP: state_nxt = DONE;
            RST:   if (cnt == RST_LAST) state_nxt = LOCKWAIT;
            LOCKWAIT: begin
                // A lock seen in the same cycle as the last timeout count wins.
                if (locked) begin
                    state_nxt = DONE;
                end else if (cnt == LOCK_LAST) begin
                    state_nxt = DONE;
                    timeout   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared cycle counter restarts on every state change.
    always_ff @(posedge mdclk) begin
        if (reset)                                  cnt <= '0;
        else if (state_nxt != state)                cnt <= '0;
        else if (state == RST || state == LOCKWAIT) cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge mdclk) begin
        if (reset) begin
            cmd_q   <= 2'b00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cmd_q   <= req_cmd;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= (req_cmd == 2'b11);
            end
            if (state == RDCAP) rdata_q <= mdrdo;
`ifdef PLL_DRP_VERIFY_EN
            if (state == VCAP) begin
                rdata_q <= mdrdo;
                err_q   <= (mdrdo != wdata_q);
            end
`endif
            if (timeout) err_q <= 1'b1;
        end
    end

    // Lock qualifier: two-flop synchronizer, then four consecutive high samples.
    always_ff @(posedge mdclk) begin
        if (reset) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
            hi_cnt  <= 2'd0;
            lock_q  <= 1'b0;
        end else begin
            lock_p0 <= pll_lock;
            lock_p1 <= lock_p0;
            if (pll_rst || !lock_p1) begin
                hi_cnt <= 2'd0;
                lock_q <= 1'b0;
            end else if (hi_cnt == 2'd3) begin
                lock_q <= 1'b1;
            end else begin
                hi_cnt <= hi_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        mdopc = 2'b00;
        mdwdi = 8'h00;
        case (state)
            ADDR: begin mdopc = 2'b11; mdwdi = addr_q;  end
            WR:   begin mdopc = 2'b01; mdwdi = wdata_q; end
            RD:   mdopc = 2'b10;
`ifdef PLL_DRP_VERIFY_EN
            VRD:  mdopc = 2'b10;
`endif
            default: ;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = rdata_q;
    assign pll_rst    = (state == RST);
    assign locked     = lock_q & ~pll_rst;
    assign mdainc     = 1'b0;

endmodule

// File: doc/pll_drp_ctrl.md
PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16: number of cycles pll_rst is held high during an apply sequence (legal range 1..255).
REQ-002 Parameter LOCK_TIMEOUT, default 50000: maximum cycles to wait for a stable lock after pll_rst is released (legal range 1..2^20-1).
REQ-003 mdclk  in  1  sole clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  command request.
REQ-006 req_ready  out  1  controller can accept a command.
REQ-007 req_cmd  in  2  command: 00 write, 01 read, 10 apply (PLL reset plus lock wait), 11 reserved.
REQ-008 req_addr  in  8  DRP register address.
REQ-009 req_wdata  in  8  DRP write data.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  8  read data, valid with resp_valid.
REQ-012 resp_err  out  1  error flag, valid with resp_valid.
REQ-013 mdopc  out  2  PLL DRP opcode: 00 nop, 01 write, 10 read, 11 load address.
REQ-014 mdainc  out  1  DRP address auto-increment; held at 0.
REQ-015 mdwdi  out  8  DRP write bus.
REQ-016 mdrdo  in  8  DRP read bus.
REQ-017 pll_rst  out  1  PLL reset.
REQ-018 pll_lock  in  1  raw PLL lock, asynchronous to mdclk.
REQ-019 locked  out  1  qualified lock status.

Function
REQ-020 The FSM SHALL implement the states IDLE, ADDR, WR, RD, RDCAP, VRD, VCAP, RST, LOCKWAIT and DONE.
REQ-021 req_ready SHALL be 1 only in IDLE; a command is accepted when req_valid and req_ready are both 1, and req_addr, req_wdata and req_cmd are captured on that edge.
REQ-022 A write SHALL drive IDLE->ADDR (mdopc=11, mdwdi=addr)->WR (mdopc=01, mdwdi=data)->DONE, giving resp_valid 3 cycles after acceptance.
REQ-023 A read SHALL drive IDLE->ADDR->RD (mdopc=10)->RDCAP (capture mdrdo)->DONE, giving resp_valid 4 cycles after acceptance with resp_rdata equal to mdrdo sampled in RDCAP.
REQ-024 An apply SHALL drive IDLE->RST, holding pll_rst=1 for exactly RST_CYCLES cycles, then LOCKWAIT with pll_rst=0.
REQ-025 pll_lock SHALL pass through a 2-flop synchronizer; locked SHALL be set after 4 consecutive synchronized-high samples and cleared on any synchronized-low sample.
REQ-026 LOCKWAIT SHALL exit to DONE with resp_err=0 on the cycle locked rises; if the counter reaches LOCK_TIMEOUT first, it SHALL exit to DONE with resp_err=1.
REQ-027 locked SHALL be forced to 0 while pll_rst=1.
REQ-028 Reserved command 11 SHALL go directly to DONE with resp_err=1 and no DRP activity.
REQ-029 DONE SHALL assert resp_valid for one cycle and return to IDLE; back-to-back commands therefore have a minimum spacing of one IDLE cycle.
REQ-030 mdopc SHALL be 00 in every state not named above as driving it, and mdwdi SHALL be 0 whenever mdopc is 00.
REQ-031 resp_rdata SHALL hold its last value until the next read completes; resp_err SHALL be 0 whenever resp_valid is 0.
REQ-032 Command inputs SHALL be ignored while req_ready is 0.

Reset
REQ-033 While reset is high the FSM SHALL enter IDLE on the next edge, aborting any operation in progress, including mid-RST and mid-LOCKWAIT.
REQ-034 Reset values: req_ready=1 (after the reset edge), resp_valid=0, resp_rdata=0, resp_err=0, mdopc=00, mdwdi=0, mdainc=0, pll_rst=0, locked=0, synchronizer and all counters 0.

Configuration
REQ-035 With PLL_DRP_VERIFY_EN defined, each write SHALL continue WR->VRD (mdopc=10)->VCAP->DONE, so resp_valid occurs 5 cycles after acceptance.
REQ-036 Under PLL_DRP_VERIFY_EN, resp_err SHALL be set if mdrdo in VCAP differs from the written data, and resp_rdata SHALL carry the read-back value.
REQ-037 Without PLL_DRP_VERIFY_EN, the VRD and VCAP states SHALL NOT exist, and write resp_err SHALL always be 0.

Verification
REQ-038 Write addr 0x12, data 0xA5 -> mdopc 11/0x12 then 01/0xA5 on consecutive cycles; resp_valid 3 cycles after acceptance (5 with verify), resp_err=0.
REQ-039 Read addr 0x07 with the model returning 0x3C -> resp_rdata=0x3C, resp_valid 4 cycles after acceptance.
REQ-040 Apply with RST_CYCLES=16 and the model raising lock 100 cycles after pll_rst falls -> pll_rst high exactly 16 cycles; resp_err=0; locked=1 at resp_valid.
REQ-041 Apply with LOCK_TIMEOUT=200 and lock held low -> resp_valid with resp_err=1 exactly 200 LOCKWAIT cycles after pll_rst falls; locked=0.
REQ-042 Assert reset during LOCKWAIT and during WR -> next cycle: IDLE, pll_rst=0, mdopc=00, no resp_valid.
REQ-043 Verify build, with the model corrupting read-back to 0xA4 after a write of 0xA5 -> resp_err=1, resp_rdata=0xA4.
